// File: rtl/mem_data_arbiter_pkg.sv
// Shared definitions for requesters of the data memory arbiter.
// Owner encodings are fixed so later requesters (e.g. DMA) can extend the set.
package mem_data_arbiter_pkg;

    localparam logic [1:0] ARB_NONE = 2'd0;
    localparam logic [1:0] ARB_CORE = 2'd1;
    localparam logic [1:0] ARB_HOST = 2'd2;

    typedef enum logic [1:0] {
        OwnNone = ARB_NONE,
        OwnCore = ARB_CORE,
        OwnHost = ARB_HOST
    } rd_owner_e;

endpackage

// File: rtl/mem_data_arbiter.sv
// Arbitrates one mem_data instance between the core (priority) and a host/debug port.
// The host is force-granted after MAXWAIT ungranted cycles, stalling the core for that cycle.
module mem_data_arbiter
    import mem_data_arbiter_pkg::*;
#(
    parameter int unsigned NUBITS  = 16,
    parameter int unsigned MDATAW  = 6,
    parameter int unsigned MAXWAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_wr,
    input  logic [MDATAW-1:0] core_addr,
    input  logic [NUBITS-1:0] core_din,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [NUBITS-1:0] core_dout,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [MDATAW-1:0] host_addr,
    input  logic [NUBITS-1:0] host_din,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [NUBITS-1:0] host_dout,
    output logic              mem_wr,
    output logic [MDATAW-1:0] mem_addr_rd,
    output logic [MDATAW-1:0] mem_addr_wr,
    output logic [NUBITS-1:0] mem_din,
    input  logic [NUBITS-1:0] mem_dout
);

    localparam int unsigned WCW = $clog2(MAXWAIT + 1);
    localparam logic [WCW-1:0] WaitMax = WCW'(MAXWAIT);

    logic [WCW-1:0] wait_q, wait_d;
    rd_owner_e      owner_q, owner_d;
    logic           force_gnt;
    logic           host_sel;
    logic           core_sel;

    // Selection is left ungated by reset; only the visible grant/write strobes are
    // gated, and the registers ignore next-state while reset is held anyway.
    always_comb begin
        force_gnt = host_req && (wait_q == WaitMax);
        host_sel  = force_gnt || (!core_req && host_req);
        core_sel  = core_req && !host_sel;

        host_gnt    = rst && host_sel;
        core_stall  = core_req && host_gnt;
        mem_wr      = rst && (host_sel ? host_wr : (core_sel && core_wr));
        mem_addr_rd = host_sel ? host_addr : core_addr;
        mem_addr_wr = host_sel ? host_addr : core_addr;
        mem_din     = host_sel ? host_din : core_din;
    end

    always_comb begin
        wait_d = wait_q;
        if (!host_req || host_sel) begin
            wait_d = '0;
        end else if (wait_q != WaitMax) begin
            wait_d = wait_q + WCW'(1);
        end

        owner_d = OwnNone;
        if (host_sel && !host_wr) begin
            owner_d = OwnHost;
        end else if (core_sel && !core_wr) begin
            owner_d = OwnCore;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q  <= '0;
            owner_q <= OwnNone;
        end else begin
            wait_q  <= wait_d;
            owner_q <= owner_d;
        end
    end

    assign core_rvalid = (owner_q == OwnCore);
    assign host_rvalid = (owner_q == OwnHost);
    assign core_dout   = mem_dout;
    assign host_dout   = mem_dout;

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Self-checking bench for mem_data_arbiter with a behavioural 1-cycle memory.
// Per-cycle vectors check grant/mux outputs; a scoreboard checks read returns.
module tb_mem_data_arbiter;
    import mem_data_arbiter_pkg::*;

    localparam int unsigned NUBITS  = 16;
    localparam int unsigned MDATAW  = 6;
    localparam int unsigned MAXWAIT = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              core_req, core_wr, core_stall, core_rvalid;
    logic [MDATAW-1:0] core_addr;
    logic [NUBITS-1:0] core_din, core_dout;
    logic              host_req, host_wr, host_gnt, host_rvalid;
    logic [MDATAW-1:0] host_addr;
    logic [NUBITS-1:0] host_din, host_dout;
    logic              mem_wr;
    logic [MDATAW-1:0] mem_addr_rd, mem_addr_wr;
    logic [NUBITS-1:0] mem_din, mem_dout;

    mem_data_arbiter #(
        .NUBITS (NUBITS),
        .MDATAW (MDATAW),
        .MAXWAIT(MAXWAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_wr    (core_wr),
        .core_addr  (core_addr),
        .core_din   (core_din),
        .core_stall (core_stall),
        .core_rvalid(core_rvalid),
        .core_dout  (core_dout),
        .host_req   (host_req),
        .host_wr    (host_wr),
        .host_addr  (host_addr),
        .host_din   (host_din),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_dout  (host_dout),
        .mem_wr     (mem_wr),
        .mem_addr_rd(mem_addr_rd),
        .mem_addr_wr(mem_addr_wr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always #5 clk = ~clk;

    logic [NUBITS-1:0] mem     [64];
    logic [NUBITS-1:0] ref_mem [64];

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr_wr] <= mem_din;
        mem_dout <= mem[mem_addr_rd];
    end

    typedef struct {
        logic              cr, cw;
        logic [MDATAW-1:0] ca;
        logic [NUBITS-1:0] cd;
        logic              hr, hw;
        logic [MDATAW-1:0] ha;
        logic [NUBITS-1:0] hd;
        logic              stall, hgnt, mwr;
        logic [MDATAW-1:0] maddr;
        logic [NUBITS-1:0] mdin;
    } vec_t;

    typedef struct {
        logic [1:0]        owner;
        logic [NUBITS-1:0] data;
    } rd_exp_t;

    vec_t    vecs [21];
    rd_exp_t sb   [$];
    int      n_cmp = 0;
    int      n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Read-return scoreboard: one entry per driven cycle, due on the following cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            rd_exp_t e;
            e = sb.pop_front();
            chk("core_rvalid", 32'(core_rvalid), 32'(e.owner == ARB_CORE));
            chk("host_rvalid", 32'(host_rvalid), 32'(e.owner == ARB_HOST));
            if (e.owner == ARB_CORE) chk("core_dout", 32'(core_dout), 32'(e.data));
            if (e.owner == ARB_HOST) chk("host_dout", 32'(host_dout), 32'(e.data));
        end
    end

    task automatic drive(input vec_t v);
        core_req  = v.cr;
        core_wr   = v.cw;
        core_addr = v.ca;
        core_din  = v.cd;
        host_req  = v.hr;
        host_wr   = v.hw;
        host_addr = v.ha;
        host_din  = v.hd;
    endtask

    task automatic step(input vec_t v, input int idx);
        rd_exp_t e;
        @(negedge clk);
        drive(v);
        #1;
        chk($sformatf("core_stall[%0d]", idx), 32'(core_stall), 32'(v.stall));
        chk($sformatf("host_gnt[%0d]", idx), 32'(host_gnt), 32'(v.hgnt));
        chk($sformatf("mem_wr[%0d]", idx), 32'(mem_wr), 32'(v.mwr));
        chk($sformatf("mem_addr_rd[%0d]", idx), 32'(mem_addr_rd), 32'(v.maddr));
        chk($sformatf("mem_addr_wr[%0d]", idx), 32'(mem_addr_wr), 32'(v.maddr));
        chk($sformatf("mem_din[%0d]", idx), 32'(mem_din), 32'(v.mdin));
        e.owner = ARB_NONE;
        e.data  = '0;
        if (v.hgnt && !v.hw) begin
            e.owner = ARB_HOST;
            e.data  = ref_mem[v.maddr];
        end else if (v.cr && !v.hgnt && !v.cw) begin
            e.owner = ARB_CORE;
            e.data  = ref_mem[v.maddr];
        end
        sb.push_back(e);
        if (v.mwr) ref_mem[v.maddr] = v.mdin;
    endtask

    initial begin
        vec_t idle;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        idle = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        //            cr cw ca cd        hr hw ha hd        stall gnt mwr maddr mdin
        vecs[0]  = idle;
        vecs[1]  = '{0, 0, 0, 0,         1, 1, 5, 'h1234,   0, 1, 1, 5, 'h1234};
        vecs[2]  = '{0, 0, 7, 'h77,      1, 0, 5, 0,        0, 1, 0, 5, 0};
        vecs[3]  = '{1, 1, 9, 'h00FF,    0, 0, 0, 0,        0, 0, 1, 9, 'h00FF};
        vecs[4]  = '{0, 0, 0, 0,         1, 0, 9, 0,        0, 1, 0, 9, 0};
        vecs[5]  = '{1, 1, 1, 'hAAAA,    0, 0, 0, 0,        0, 0, 1, 1, 'hAAAA};
        // Continuous core reads against a held host read: forced slot every 4 cycles.
        for (int i = 6; i <= 13; i++)
            vecs[i] = '{1, 0, 5, 0,      1, 0, 1, 'h5555,   0, 0, 0, 5, 0};
        vecs[9]  = '{1, 0, 5, 0,         1, 0, 1, 'h5555,   1, 1, 0, 1, 'h5555};
        vecs[13] = vecs[9];
        // Core idle cycle mid-wait grants the host and restarts the count.
        vecs[14] = '{1, 0, 5, 0,         1, 0, 9, 0,        0, 0, 0, 5, 0};
        vecs[15] = '{0, 0, 5, 0,         1, 0, 9, 0,        0, 1, 0, 9, 0};
        vecs[16] = vecs[14];
        vecs[17] = vecs[14];
        vecs[18] = vecs[14];
        vecs[19] = '{1, 0, 5, 0,         1, 0, 9, 0,        1, 1, 0, 9, 0};
        vecs[20] = idle;

        // Reset held with both sides requesting writes.
        drive('{1, 1, 3, 'hBEEF, 1, 1, 4, 'hCAFE, 0, 0, 0, 0, 0});
        #3;
        chk("reset mem_wr", 32'(mem_wr), 0);
        chk("reset host_gnt", 32'(host_gnt), 0);
        chk("reset core_stall", 32'(core_stall), 0);
        chk("reset core_rvalid", 32'(core_rvalid), 0);
        chk("reset host_rvalid", 32'(host_rvalid), 0);
        @(posedge clk);
        @(negedge clk);
        drive(idle);
        rst = 1'b1;

        for (int i = 0; i < 21; i++) step(vecs[i], i);

        // Host read granted, then reset asserted before the edge that would commit it.
        @(negedge clk);
        drive('{0, 0, 0, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0});
        #1;
        chk("pre-reset host_gnt", 32'(host_gnt), 1);
        #1;
        rst = 1'b0;
        host_wr = 1'b1;
        #1;
        chk("mid-reset host_gnt", 32'(host_gnt), 0);
        chk("mid-reset host mem_wr", 32'(mem_wr), 0);
        core_req = 1'b1;
        core_wr  = 1'b1;
        #1;
        chk("mid-reset core mem_wr", 32'(mem_wr), 0);
        chk("mid-reset core_stall", 32'(core_stall), 0);
        @(posedge clk);
        #2;
        chk("dropped host_rvalid", 32'(host_rvalid), 0);
        chk("dropped core_rvalid", 32'(core_rvalid), 0);
        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        // Counter restarted: core wins three contended cycles, host forced on the fourth.
        for (int i = 6; i <= 9; i++) step(vecs[i], 100 + i);
        step(idle, 120);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_data_arbiter.md
# mem_data_arbiter

Shares one `mem_data` instance (single write port, single read port, 1-cycle registered read) between the processor core and an external host/debug port. The core has priority; the host gets idle cycles and is force-granted after a bounded wait, with the core stalled for that one cycle. It sits between `core` and `mdata` inside the processor top level.

## Interface
- `NUBITS`, 16: data word width
- `MDATAW`, 6: data memory address width
- `MAXWAIT`, 8: maximum consecutive ungranted host-request cycles before a forced host grant; must be at least 1
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `core_req` in 1: core access request this cycle
- `core_wr` in 1: 1 = write, 0 = read
- `core_addr` in MDATAW: core address
- `core_din` in NUBITS: core write data
- `core_stall` out 1: core request not served this cycle; the core must hold its request
- `core_rvalid` out 1: core read data valid
- `core_dout` out NUBITS: core read data
- `host_req` in 1: host access request
- `host_wr` in 1: host write/read select
- `host_addr` in MDATAW: host address
- `host_din` in NUBITS: host write data
- `host_gnt` out 1: host request served this cycle
- `host_rvalid` out 1: host read data valid
- `host_dout` out NUBITS: host read data
- `mem_wr` out 1: memory write enable
- `mem_addr_rd` out MDATAW: memory read address
- `mem_addr_wr` out MDATAW: memory write address
- `mem_din` out NUBITS: memory write data
- `mem_dout` in NUBITS: memory read data, 1 cycle after the address

## Operation
- Grant is combinational per cycle:
  - `force = (wait_cnt == MAXWAIT) && host_req`.
  - If `force`, the host is granted.
  - Otherwise, if `core_req`, the core is granted.
  - Otherwise, if `host_req`, the host is granted.
  - Otherwise there is no grant.
- `core_stall = core_req && host_gnt`.
- Memory side mux:
  - The granted requester's address drives both `mem_addr_rd` and `mem_addr_wr`.
  - The granted requester's write data drives `mem_din`.
  - `mem_wr` = granted requester's write flag. It is 0 when there is no grant and 0 while `rst` is low.
  - With no grant, the address and data outputs hold the core inputs.
- Read return:
  - Registered `rd_owner` ∈ {NONE, CORE, HOST} is set from a granted read; writes and no grant set NONE.
  - `core_rvalid = (rd_owner == CORE)`, `host_rvalid = (rd_owner == HOST)`.
  - `core_dout` and `host_dout` are both wired to `mem_dout`.
- Starvation counter `wait_cnt`, width `$clog2(MAXWAIT+1)`:
  - Increments when `host_req && !host_gnt`, saturating at MAXWAIT.
  - Clears when `host_gnt` or `!host_req`.
- Forced grant lasts exactly one access. The counter then restarts from 0, so a continuously requesting host under continuous core traffic gets one slot every MAXWAIT+1 cycles.
- Same-address write and read in consecutive cycles by different requesters: the memory ordering applies (a read issued the cycle after a write sees the new data).
- A write and a read in the same cycle cannot occur: one grant per cycle.

## Timing
- Reset (`rst` low, asynchronous): `wait_cnt`=0, `rd_owner`=NONE, so `core_rvalid`=`host_rvalid`=0. `mem_wr`=0 and `host_gnt`=0 while reset is held.
- Grant and stall decisions are valid in the same cycle as the request (no added latency).
- Read latency is 1 cycle: a granted read at edge t gives `*_rvalid`=1 with data during cycle t+1.
- Write commits at the edge ending the grant cycle.
- Reset asserted mid-operation: a pending `rvalid` is dropped (never delivered). The requester re-issues after reset.
- Host wait is bounded at MAXWAIT+1 cycles from request to grant. Core stall is at most 1 cycle per forced grant.
- Host handshake: the host must hold `host_req` and its address/data stable until it sees `host_gnt`=1. It may drop `host_req` the cycle after.

## Structure
- Shared package: `rd_owner` enum (NONE, CORE, HOST) and the `ARB_` owner constants, reused by future requesters such as DMA.
- No sub-module. The counter, the mux and the `rd_owner` register stay inline.

## Test plan
- Host only: host write addr 5 data 0x1234, then host read addr 5 → `host_gnt`=1 each cycle; `host_rvalid`=1 one cycle later with `host_dout`=0x1234; `core_rvalid` stays 0.
- Core continuous reads with host_req held, MAXWAIT=3 → host granted on the 4th waiting cycle; `core_stall`=1 for exactly that cycle; the core read resumes next cycle; pattern repeats every 4 cycles.
- Core idle cycle during a host wait (wait_cnt=1) → host granted immediately; `wait_cnt` returns to 0; no core stall.
- Core write addr 9 0x00FF, next cycle host read addr 9 → `host_dout`=0x00FF with `host_rvalid`.
- Host read granted, then `rst` pulsed low before the next edge → `host_rvalid` never asserts; `mem_wr`=0 during reset; after release `wait_cnt`=0 and the core wins the first contended cycle.
- Both idle → `mem_wr`=0, both `rvalid`=0, `wait_cnt`=0.
